// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, screen size and default
// obstacle/player geometry (also used by the renderer to draw obstacles).
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } game_state_t;

  localparam int SCREEN_W = 1920;
  localparam int SCREEN_H = 1080;

  localparam int COORD_W = 13;

  localparam int PLAYER_SIZE_DEF  = 40;
  localparam int OBS_W_DEF        = 60;
  localparam int OBS_H_DEF        = 30;
  localparam int OBS1_Y_DEF       = 300;
  localparam int OBS2_Y_DEF       = 600;
  localparam int OBS3_Y_DEF       = 900;
  localparam int LIVES_INIT_DEF   = 3;
  localparam int INVULN_TICKS_DEF = 8;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test on 13-bit signed coordinates.
// Strict compares, so boxes that only share an edge do not overlap.
module box_overlap
  import game_pkg::*;
#(
  parameter int A_W = PLAYER_SIZE_DEF,
  parameter int A_H = PLAYER_SIZE_DEF,
  parameter int B_W = OBS_W_DEF,
  parameter int B_H = OBS_H_DEF
) (
  input  logic signed [COORD_W-1:0] ax,
  input  logic signed [COORD_W-1:0] ay,
  input  logic signed [COORD_W-1:0] bx,
  input  logic signed [COORD_W-1:0] by,
  output logic                      hit
);

  localparam logic signed [COORD_W-1:0] AW = COORD_W'(A_W);
  localparam logic signed [COORD_W-1:0] AH = COORD_W'(A_H);
  localparam logic signed [COORD_W-1:0] BW = COORD_W'(B_W);
  localparam logic signed [COORD_W-1:0] BH = COORD_W'(B_H);

  logic signed [COORD_W-1:0] a_right, a_bottom, b_right, b_bottom;

  assign a_right  = ax + AW;
  assign a_bottom = ay + AH;
  assign b_right  = bx + BW;
  assign b_bottom = by + BH;

  assign hit = (ax < b_right) && (bx < a_right) &&
               (ay < b_bottom) && (by < a_bottom);

endmodule

// File: rtl/collision_game_ctrl.sv
// Game logic: registered player/obstacle collision detect feeding a
// lives/score FSM that drives renderer status flags and the mover freeze.
module collision_game_ctrl
  import game_pkg::*;
#(
  parameter int PLAYER_SIZE  = PLAYER_SIZE_DEF,
  parameter int OBS_W        = OBS_W_DEF,
  parameter int OBS_H        = OBS_H_DEF,
  parameter int OBS1_Y       = OBS1_Y_DEF,
  parameter int OBS2_Y       = OBS2_Y_DEF,
  parameter int OBS3_Y       = OBS3_Y_DEF,
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int INVULN_TICKS = INVULN_TICKS_DEF
) (
  input  logic        clk_148Mhz,
  input  logic        reset,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic [10:0] x_obs1,
  input  logic [10:0] x_obs2,
  input  logic [10:0] x_obs3,
  input  logic        tick,
  input  logic        start,
  output logic        freeze,
  output logic        game_active,
  output logic        game_over,
  output logic        hit_flash,
  output logic [1:0]  lives,
  output logic [15:0] score
);

  localparam int CNT_W = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(INVULN_TICKS - 1);
  localparam logic [1:0]       LIVES_FULL = 2'(LIVES_INIT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [COORD_W-1:0] px_p0, py_p0;
  logic signed [COORD_W-1:0] ox1_p0, ox2_p0, ox3_p0;
  logic                      hit1_p0, hit2_p0, hit3_p0;
  logic                      coll_p1;

  assign px_p0  = $signed({x_pos[11], x_pos});
  assign py_p0  = $signed({y_pos[11], y_pos});
  assign ox1_p0 = $signed({2'b00, x_obs1});
  assign ox2_p0 = $signed({2'b00, x_obs2});
  assign ox3_p0 = $signed({2'b00, x_obs3});

  box_overlap #(.A_W(PLAYER_SIZE), .A_H(PLAYER_SIZE), .B_W(OBS_W), .B_H(OBS_H)) u_ov1 (
    .ax(px_p0), .ay(py_p0), .bx(ox1_p0), .by(COORD_W'(OBS1_Y)), .hit(hit1_p0)
  );
  box_overlap #(.A_W(PLAYER_SIZE), .A_H(PLAYER_SIZE), .B_W(OBS_W), .B_H(OBS_H)) u_ov2 (
    .ax(px_p0), .ay(py_p0), .bx(ox2_p0), .by(COORD_W'(OBS2_Y)), .hit(hit2_p0)
  );
  box_overlap #(.A_W(PLAYER_SIZE), .A_H(PLAYER_SIZE), .B_W(OBS_W), .B_H(OBS_H)) u_ov3 (
    .ax(px_p0), .ay(py_p0), .bx(ox3_p0), .by(COORD_W'(OBS3_Y)), .hit(hit3_p0)
  );

  // p0 -> p1: register the combined overlap
  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) coll_p1 <= 1'b0;
    else        coll_p1 <= hit1_p0 | hit2_p0 | hit3_p0;
  end

  game_state_t      state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [15:0]      score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  logic             freeze_q, active_q, over_q;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_FULL;
          score_d = 16'd0;
          flash_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (tick) score_d = sat_inc16(score_q);
        // A hit wins over start; start has no effect while playing anyway
        if (coll_p1) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            cnt_d   = '0;
            flash_d = 1'b0;
            state_d = ST_INVULN;
          end else begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end
        end
      end
      ST_INVULN: begin
        if (tick) begin
          score_d = sat_inc16(score_q);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            flash_d = 1'b0;
            state_d = ST_PLAY;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // p1 -> p2: state and registered status outputs
  always_ff @(posedge clk_148Mhz or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lives_q  <= LIVES_FULL;
      score_q  <= 16'd0;
      cnt_q    <= '0;
      flash_q  <= 1'b0;
      freeze_q <= 1'b1;
      active_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      flash_q  <= flash_d;
      freeze_q <= (state_d == ST_IDLE) || (state_d == ST_OVER);
      active_q <= (state_d == ST_PLAY) || (state_d == ST_INVULN);
      over_q   <= (state_d == ST_OVER);
    end
  end

  assign freeze      = freeze_q;
  assign game_active = active_q;
  assign game_over   = over_q;
  assign hit_flash   = flash_q;
  assign lives       = lives_q;
  assign score       = score_q;

endmodule

// File: tb/tb_collision_game_ctrl.sv
// Directed bench for collision_game_ctrl: collision geometry, lives/score
// FSM, invulnerability window, saturation and asynchronous reset.
module tb_collision_game_ctrl;
  import game_pkg::*;

  logic        clk_148Mhz = 1'b0;
  logic        reset;
  logic [11:0] x_pos, y_pos;
  logic [10:0] x_obs1, x_obs2, x_obs3;
  logic        tick, start;
  logic        freeze, game_active, game_over, hit_flash;
  logic [1:0]  lives;
  logic [15:0] score;

  int tests_run    = 0;
  int tests_failed = 0;

  collision_game_ctrl dut (
    .clk_148Mhz (clk_148Mhz),
    .reset      (reset),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .x_obs1     (x_obs1),
    .x_obs2     (x_obs2),
    .x_obs3     (x_obs3),
    .tick       (tick),
    .start      (start),
    .freeze     (freeze),
    .game_active(game_active),
    .game_over  (game_over),
    .hit_flash  (hit_flash),
    .lives      (lives),
    .score      (score)
  );

  always #5 clk_148Mhz = ~clk_148Mhz;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk_148Mhz);
      #1;
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cycle(1);
    tick = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    cycle(1);
  endtask

  task automatic test_reset();
    #7;
    tests_run++;
    if ({freeze, game_active, game_over, hit_flash} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 1000", {freeze, game_active, game_over, hit_flash});
    end
    tests_run++;
    if (lives !== 2'd3 || score !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: lives=%0d score=%0d expected 3/0", lives, score);
    end
    cycle(1);
    reset = 1'b1;
    cycle(1);
  endtask

  task automatic test_start_ticks();
    x_pos = 12'd100; y_pos = 12'd100;
    start_pulse();
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      cycle(1);
    end
    tests_run++;
    if (dut.state_q !== ST_PLAY || freeze !== 1'b0 || game_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_play: state=%0d freeze=%b active=%b expected PLAY/0/1", dut.state_q, freeze, game_active);
    end
    tests_run++;
    if (score !== 16'd5 || lives !== 2'd3) begin
      tests_failed++;
      $display("FAIL start_score: score=%0d lives=%0d expected 5/3", score, lives);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    x_pos = 12'd500; y_pos = 12'd300;
    x_obs1 = 11'd441;
    cycle(1);
    tests_run++;
    if (dut.coll_p1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL overlap_441: coll=%b expected 1", dut.coll_p1);
    end
    x_obs1 = 11'd440;
    cycle(1);
    tests_run++;
    if (dut.coll_p1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL touch_440: coll=%b expected 0", dut.coll_p1);
    end
    start_pulse();
    x_obs1 = 11'd460;
    cycle(1);
    tests_run++;
    if (dut.coll_p1 !== 1'b1 || lives !== 2'd3) begin
      tests_failed++;
      $display("FAIL hit_latency1: coll=%b lives=%0d expected 1/3", dut.coll_p1, lives);
    end
    cycle(1);
    tests_run++;
    if (lives !== 2'd2 || dut.state_q !== ST_INVULN || hit_flash !== 1'b0 || game_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_latency2: lives=%0d state=%0d flash=%b active=%b expected 2/INVULN/0/1",
               lives, dut.state_q, hit_flash, game_active);
    end
  endtask

  task automatic test_invuln();
    logic exp_flash;
    int   toggles;
    logic prev;
    toggles = 0;
    prev = hit_flash;
    for (int k = 1; k <= 8; k++) begin
      tick_pulse();
      exp_flash = (k < 8) ? k[0] : 1'b0;
      if (hit_flash !== prev) toggles++;
      prev = hit_flash;
      tests_run++;
      if (hit_flash !== exp_flash || lives !== 2'd2) begin
        tests_failed++;
        $display("FAIL invuln_tick%0d: flash=%b lives=%0d expected %b/2", k, hit_flash, lives, exp_flash);
      end
    end
    tests_run++;
    if (toggles !== 8) begin
      tests_failed++;
      $display("FAIL invuln_toggles: got %0d expected 8", toggles);
    end
    tests_run++;
    if (dut.state_q !== ST_PLAY || score !== 16'd8) begin
      tests_failed++;
      $display("FAIL invuln_exit: state=%0d score=%0d expected PLAY/8", dut.state_q, score);
    end
    cycle(1);
    tests_run++;
    if (lives !== 2'd1 || dut.state_q !== ST_INVULN) begin
      tests_failed++;
      $display("FAIL rehit: lives=%0d state=%0d expected 1/INVULN", lives, dut.state_q);
    end
  endtask

  task automatic test_over();
    for (int k = 0; k < 8; k++) tick_pulse();
    cycle(1);
    tests_run++;
    if (lives !== 2'd0 || game_over !== 1'b1 || freeze !== 1'b1 || game_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_enter: lives=%0d over=%b freeze=%b active=%b expected 0/1/1/0",
               lives, game_over, freeze, game_active);
    end
    for (int k = 0; k < 3; k++) tick_pulse();
    tests_run++;
    if (score !== 16'd16) begin
      tests_failed++;
      $display("FAIL over_score_hold: score=%0d expected 16", score);
    end
    x_obs1 = 11'd2000;
    cycle(1);
    start_pulse();
    tests_run++;
    if (lives !== 2'd3 || score !== 16'd0 || dut.state_q !== ST_PLAY || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_restart: lives=%0d score=%0d state=%0d over=%b expected 3/0/PLAY/0",
               lives, score, dut.state_q, game_over);
    end
  endtask

  task automatic test_same_cycle();
    tick_pulse();
    tick_pulse();
    x_obs1 = 11'd460;
    cycle(1);
    tests_run++;
    if (lives !== 2'd3 || score !== 16'd2) begin
      tests_failed++;
      $display("FAIL same_pre: lives=%0d score=%0d expected 3/2", lives, score);
    end
    tick = 1'b1; start = 1'b1;
    cycle(1);
    tick = 1'b0; start = 1'b0;
    tests_run++;
    if (score !== 16'd3 || lives !== 2'd2 || dut.state_q !== ST_INVULN) begin
      tests_failed++;
      $display("FAIL same_cycle: score=%0d lives=%0d state=%0d expected 3/2/INVULN", score, lives, dut.state_q);
    end
  endtask

  task automatic test_async_reset();
    tick_pulse();
    tests_run++;
    if (hit_flash !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre_flash: flash=%b expected 1", hit_flash);
    end
    #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({freeze, game_active, game_over, hit_flash} !== 4'b1000 || lives !== 2'd3 ||
        score !== 16'd0 || dut.state_q !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL async_reset: flags=%b lives=%0d score=%0d state=%0d expected 1000/3/0/IDLE",
               {freeze, game_active, game_over, hit_flash}, lives, score, dut.state_q);
    end
    #2;
    reset = 1'b1;
    cycle(1);
  endtask

  task automatic test_saturation();
    x_obs1 = 11'd2000;
    x_pos = 12'd100; y_pos = 12'd100;
    cycle(1);
    start_pulse();
    tick = 1'b1;
    cycle(65534);
    tests_run++;
    if (score !== 16'd65534) begin
      tests_failed++;
      $display("FAIL sat_preload: score=%0d expected 65534", score);
    end
    cycle(3);
    tick = 1'b0;
    tests_run++;
    if (score !== 16'd65535) begin
      tests_failed++;
      $display("FAIL sat_hold: score=%0d expected 65535", score);
    end
  endtask

  initial begin
    reset = 1'b0;
    x_pos = 12'd100; y_pos = 12'd100;
    x_obs1 = 11'd2000; x_obs2 = 11'd2000; x_obs3 = 11'd2000;
    tick = 1'b0; start = 1'b0;
    test_reset();
    test_start_ticks();
    test_overlap();
    test_invuln();
    test_over();
    test_same_cycle();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
